// File: rtl/tick_divider_pkg.sv
// -----------------------------------------------------------------------------
// tick_divider_pkg
// Shared constants, defaults and types for the tick_divider block.
//   CLK_HZ          : system clock frequency the defaults are derived from
//   WIDTH_DEF       : default bit width of period/counter registers
//   DEFAULT_DIV_DEF : default reset period (one second at CLK_HZ)
//   N_CH_MAX        : largest supported channel count
//   LOAD_CH_W       : width of the LOAD_CH channel index
//   ch_act_e        : per-channel action decoded for each clock edge
//   div_fits()      : true when a period is nonzero and fits in a given width
// -----------------------------------------------------------------------------
package tick_divider_pkg;

   localparam int unsigned     CLK_HZ          = 50_000_000;
   localparam int unsigned     WIDTH_DEF       = 26;
   localparam longint unsigned DEFAULT_DIV_DEF = 64'd50_000_000;
   localparam int unsigned     N_CH_MAX        = 16;
   localparam int unsigned     LOAD_CH_W       = 4;

   // What a channel does on a given edge; SYNC outranks everything but reset.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_COUNT = 2'd1,
      ACT_WRAP  = 2'd2,
      ACT_SYNC  = 2'd3
   } ch_act_e;

   // Guarded shift: shifting a 64-bit value by 64 or more is not meaningful.
   function automatic logic div_fits(input longint unsigned div,
                                     input int unsigned     width);
      if (div == 64'd0)
         return 1'b0;
      if (width >= 64)
         return 1'b1;
      return (div >> width) == 64'd0;
   endfunction

endpackage : tick_divider_pkg

// File: rtl/tick_div_ch.sv
// -----------------------------------------------------------------------------
// tick_div_ch
// One divider channel: active period P, shadow period S, counter C, pending
// flag, registered tick pulse and square wave.
// Ports:
//   i_clk      : system clock (rising edge)
//   i_rst      : synchronous active-high reset
//   i_run      : channel is running (global enable AND channel enable)
//   i_sync     : restart strobe, common to all channels
//   i_ld       : accepted load addressed to this channel
//   i_ld_val   : period carried by the load (already known to be nonzero)
//   o_tick     : one-cycle pulse on each completed period
//   o_sqw      : toggles on every tick
//   o_pend     : a shadow period is waiting for the next wrap
// -----------------------------------------------------------------------------
module tick_div_ch
   import tick_divider_pkg::*;
#(
   parameter int unsigned      WIDTH   = WIDTH_DEF,
   parameter logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV_DEF)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_sync,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_ld_val,
   output logic             o_tick,
   output logic             o_sqw,
   output logic             o_pend
);

   logic [WIDTH-1:0] r_per;
   logic [WIDTH-1:0] r_shd;
   logic [WIDTH-1:0] r_cnt;
   logic             r_pend;
   logic             r_tick;
   logic             r_sqw;

   logic [WIDTH-1:0] w_last;
   ch_act_e          w_act;

   // Periods are always >= 1, so P-1 never underflows.
   assign w_last = r_per - WIDTH'(1);

   always_comb begin
      w_act = ACT_HOLD;
      if (i_sync)
         w_act = ACT_SYNC;
      else if (i_run)
         w_act = (r_cnt == w_last) ? ACT_WRAP : ACT_COUNT;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_per  <= RST_DIV;
         r_shd  <= RST_DIV;
         r_cnt  <= '0;
         r_pend <= 1'b0;
         r_tick <= 1'b0;
         r_sqw  <= 1'b0;
      end else begin
         unique case (w_act)
            ACT_SYNC: begin
               // Restart in phase; any waiting period becomes active now.
               // A load arriving with the strobe is applied immediately too.
               r_cnt  <= '0;
               r_tick <= 1'b0;
               r_sqw  <= 1'b0;
               r_pend <= 1'b0;
               if (i_ld) begin
                  r_per <= i_ld_val;
                  r_shd <= i_ld_val;
               end else if (r_pend) begin
                  r_per <= r_shd;
               end
            end
            ACT_WRAP: begin
               // A load on the wrap edge itself takes effect here, so it
               // never shows up as pending.
               r_cnt  <= '0;
               r_tick <= 1'b1;
               r_sqw  <= ~r_sqw;
               r_pend <= 1'b0;
               if (i_ld) begin
                  r_per <= i_ld_val;
                  r_shd <= i_ld_val;
               end else if (r_pend) begin
                  r_per <= r_shd;
               end
            end
            ACT_COUNT: begin
               r_cnt  <= r_cnt + WIDTH'(1);
               r_tick <= 1'b0;
               if (i_ld) begin
                  r_shd  <= i_ld_val;
                  r_pend <= 1'b1;
               end
            end
            default: begin
               // Stopped: hold phase; a load replaces the period outright and
               // restarts the count so C stays below the new P.
               r_tick <= 1'b0;
               if (i_ld) begin
                  r_per  <= i_ld_val;
                  r_shd  <= i_ld_val;
                  r_cnt  <= '0;
                  r_pend <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_tick = r_tick;
   assign o_sqw  = r_sqw;
   assign o_pend = r_pend;

endmodule : tick_div_ch

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// N_CH independent programmable tick dividers with a shared restart strobe and
// a shadowed, glitch-free period reload path.
// Ports:
//   CLK       : system clock (rising edge)
//   RST       : synchronous active-high reset
//   EN        : global run enable
//   CH_EN     : per-channel run enable
//   SYNC      : restart all channels in phase (one-cycle strobe)
//   LOAD      : request a new period (one-cycle strobe)
//   LOAD_CH   : target channel index for LOAD
//   LOAD_VAL  : requested period in clock cycles
//   TICK      : one-cycle pulse per completed period, per channel
//   SQW       : square wave toggling on each tick, per channel
//   PEND      : a loaded period is waiting for the next wrap, per channel
//   LOAD_ERR  : one-cycle pulse when a LOAD is rejected
// -----------------------------------------------------------------------------
module tick_divider
   import tick_divider_pkg::*;
#(
   parameter int unsigned     N_CH        = 4,
   parameter int unsigned     WIDTH       = WIDTH_DEF,
   parameter longint unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic [N_CH-1:0]      CH_EN,
   input  logic                 SYNC,
   input  logic                 LOAD,
   input  logic [LOAD_CH_W-1:0] LOAD_CH,
   input  logic [WIDTH-1:0]     LOAD_VAL,
   output logic [N_CH-1:0]      TICK,
   output logic [N_CH-1:0]      SQW,
   output logic [N_CH-1:0]      PEND,
   output logic                 LOAD_ERR
);

   // Reject impossible configurations at elaboration time.
   if (!div_fits(DEFAULT_DIV, WIDTH)) begin : g_bad_div
      $error("tick_divider: DEFAULT_DIV must be nonzero and fit in WIDTH bits");
   end
   if ((N_CH < 1) || (N_CH > N_CH_MAX)) begin : g_bad_nch
      $error("tick_divider: N_CH must be in 1..N_CH_MAX");
   end

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   logic w_ch_ok;
   logic w_val_ok;
   logic w_load_ok;
   logic r_load_err;

   // A load is accepted only for a real channel and a nonzero period;
   // anything else leaves every channel untouched.
   assign w_ch_ok   = 32'(LOAD_CH) < N_CH;
   assign w_val_ok  = LOAD_VAL != '0;
   assign w_load_ok = LOAD && w_ch_ok && w_val_ok;

   always_ff @(posedge CLK) begin
      if (RST)
         r_load_err <= 1'b0;
      else
         r_load_err <= LOAD && !w_load_ok;
   end

   assign LOAD_ERR = r_load_err;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic w_run;
      logic w_ld;

      assign w_run = EN && CH_EN[i];
      assign w_ld  = w_load_ok && (LOAD_CH == LOAD_CH_W'(i));

      tick_div_ch #(
         .WIDTH   (WIDTH),
         .RST_DIV (RST_DIV)
      ) u_ch (
         .i_clk    (CLK),
         .i_rst    (RST),
         .i_run    (w_run),
         .i_sync   (SYNC),
         .i_ld     (w_ld),
         .i_ld_val (LOAD_VAL),
         .o_tick   (TICK[i]),
         .o_sqw    (SQW[i]),
         .o_pend   (PEND[i])
      );
   end

endmodule : tick_divider

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 26, bit width of each period and counter register.
REQ-003 SHALL have parameter DEFAULT_DIV, default 50_000_000, period loaded into every channel at reset (1 s at the 50 MHz system clock).
REQ-004 SHALL have port CLK  input  1  system clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port EN  input  1  global run enable.
REQ-007 SHALL have port CH_EN  input  N_CH  per-channel run enable.
REQ-008 SHALL have port SYNC  input  1  one-cycle strobe that restarts all channels in phase.
REQ-009 SHALL have port LOAD  input  1  one-cycle strobe that requests a new period.
REQ-010 SHALL have port LOAD_CH  input  4  target channel index for LOAD.
REQ-011 SHALL have port LOAD_VAL  input  WIDTH  requested period in clock cycles.
REQ-012 SHALL have port TICK  output  N_CH  registered one-cycle pulse per completed period.
REQ-013 SHALL have port SQW  output  N_CH  registered square wave that toggles on each tick.
REQ-014 SHALL have port PEND  output  N_CH  high while a loaded period is waiting to be applied.
REQ-015 SHALL have port LOAD_ERR  output  1  registered one-cycle pulse when a LOAD is rejected.

Function
REQ-016 Each channel SHALL hold an active period P, a shadow period S and a counter C; a channel is running when EN and CH_EN[i] are both 1.
REQ-017 On a running edge with C != P-1, the channel SHALL set C to C+1 and drive TICK[i] to 0.
REQ-018 On a running edge with C == P-1 (wrap), the channel SHALL set C to 0, drive TICK[i] to 1 and toggle SQW[i], so ticks repeat every P cycles.
REQ-019 With P=DEFAULT_DIV, the first TICK SHALL be high after the P-th rising edge following RST deassertion.
REQ-020 When not running, the channel SHALL hold C and SQW[i] and drive TICK[i] to 0; counting resumes from the held C.
REQ-021 A LOAD with LOAD_VAL >= 1 and LOAD_CH < N_CH SHALL write S and set PEND[LOAD_CH] on the next edge.
REQ-022 A pending S SHALL become P at the channel's next wrap edge, and PEND SHALL clear on that edge.
REQ-023 A LOAD on the same edge as a wrap of its target channel SHALL take effect at that wrap; PEND SHALL stay low.
REQ-024 A LOAD to a channel that is not running SHALL write P directly, clear C to 0 and leave PEND low.
REQ-025 A second LOAD before the first is applied SHALL overwrite S; last write wins.
REQ-026 A LOAD with LOAD_VAL == 0 or LOAD_CH >= N_CH SHALL change no state and SHALL pulse LOAD_ERR for one cycle.
REQ-027 SYNC SHALL set C to 0, SQW to 0 and TICK to 0 on all channels.
REQ-028 SYNC SHALL apply every pending S to P and clear all PEND bits.
REQ-029 SYNC SHALL take priority over a coincident wrap, so no tick is produced on that edge.
REQ-030 P=1 SHALL hold TICK high continuously while running, with SQW toggling every cycle.
REQ-031 Counter arithmetic SHALL be unsigned WIDTH-bit, and C SHALL never exceed P-1.

Reset
REQ-032 On RST, every P SHALL be set to DEFAULT_DIV, and every S to DEFAULT_DIV.
REQ-033 On RST, every C SHALL be set to 0, and TICK, SQW, PEND and LOAD_ERR SHALL be 0.
REQ-034 RST SHALL override SYNC and LOAD on the same edge, and SHALL discard pending loads when asserted mid-operation.

Structure
REQ-035 Package tick_divider_pkg SHALL hold CLK_HZ (50_000_000), the WIDTH default, the DEFAULT_DIV default and the N_CH maximum.
REQ-036 Elaboration SHALL fail if DEFAULT_DIV is 0 or does not fit in WIDTH bits.
REQ-037 Per-channel logic SHALL be sub-module tick_div_ch (P, S, C, PEND, TICK, SQW), instantiated N_CH times by generate.
REQ-038 Load decode and LOAD_ERR generation SHALL live in the tick_divider top level.

Verification
REQ-039 Reset release with DEFAULT_DIV=5, N_CH=3 and all channels enabled -> TICK[0..2] high at edges 5, 10 and 15; SQW goes 1, 0, 1.
REQ-040 LOAD ch1 with value 3 at C=2 -> PEND[1]=1; the wrap at edge 5 applies the new period, then ticks come every 3 cycles; PEND[1]=0 after the wrap.
REQ-041 LOAD_VAL=0, then LOAD_CH=3 with N_CH=3 -> LOAD_ERR pulses once per request; periods stay at 5; PEND stays 0.
REQ-042 CH_EN[2] low for 7 cycles at C=2 -> no TICK[2] during the gap; TICK[2] high at the 3rd edge after re-enable.
REQ-043 SYNC coincident with a ch0 wrap -> TICK=0 and SQW=0 on all channels; next ticks at SYNC+5.
REQ-044 RST mid-period with PEND[1]=1 -> all outputs 0, P=5 on all channels; first TICK at the 5th edge after release.
